spram_fifo_ctrl: RTL and testbench
==================================

SPRAM_FIFO_CTRL -- requirements
Module: spram_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: RAM entries; power of two, >= 4.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1: reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1: upstream data valid.
REQ-006 SHALL have port in_ready  out  1: FIFO accepts in_data this cycle.
REQ-007 SHALL have port in_data  in  WIDTH: write payload.
REQ-008 SHALL have port out_valid  out  1: out_data holds the oldest entry.
REQ-009 SHALL have port out_ready  in  1: downstream consumes when out_valid is high.
REQ-010 SHALL have port out_data  out  WIDTH: head payload.
REQ-011 SHALL have port count  out  $clog2(DEPTH+3): entries held (RAM + read in flight + output buffer).
REQ-012 SHALL have port ram_wen  out  1: RAM write strobe.
REQ-013 SHALL have port ram_ren  out  1: RAM read strobe.
REQ-014 SHALL have port ram_waddr  out  $clog2(DEPTH): RAM write address.
REQ-015 SHALL have port ram_raddr  out  $clog2(DEPTH): RAM read address.
REQ-016 SHALL have port ram_wdata  out  WIDTH: RAM write data.
REQ-017 SHALL have port ram_rdata  in  WIDTH: RAM read data, valid the cycle after ram_ren.

Function
REQ-018 SHALL drive the single-port RAM so that ram_wen and ram_ren are never high in the same cycle.
REQ-019 SHALL hold state: wptr, rptr (wrapping $clog2(DEPTH)-bit), ram_cnt (0..DEPTH), rd_pend (1 bit), 2-entry output buffer with obuf_cnt (0..2).
REQ-020 SHALL compute rd_issue = (ram_cnt != 0) && (obuf_cnt + rd_pend < 2), from registered state only (no combinational path from in_valid or out_ready).
REQ-021 SHALL give reads priority: in_ready = (ram_cnt < DEPTH) && !rd_issue.
REQ-022 SHALL on push (in_valid && in_ready) assert ram_wen, ram_waddr = wptr, ram_wdata = in_data, and increment wptr modulo DEPTH.
REQ-023 SHALL on rd_issue assert ram_ren, ram_raddr = rptr, increment rptr modulo DEPTH, decrement ram_cnt, and set rd_pend for the next cycle.
REQ-024 SHALL, in a cycle with rd_pend high, append ram_rdata to the output buffer tail.
REQ-025 SHALL present the buffer head on out_data/out_valid (out_valid = obuf_cnt != 0); pop on out_valid && out_ready; same-cycle capture and pop both apply, preserving order.
REQ-026 SHALL have latency: push in cycle T -> out_valid in cycle T+3 when empty.
REQ-027 SHALL update ram_cnt by +push -read in one cycle when both occur on different cycles' bookkeeping; count = ram_cnt + rd_pend + obuf_cnt.
REQ-028 SHALL hold out_data stable while out_valid && !out_ready.
REQ-029 SHALL at ram_cnt == DEPTH deassert in_ready; at count == 0 deassert out_valid and ram_ren.

Reset
REQ-030 SHALL, while rst is high, clear wptr, rptr, ram_cnt, rd_pend, obuf_cnt; outputs in_ready=0, out_valid=0, count=0, ram_wen=0, ram_ren=0, addresses and data 0.
REQ-031 SHALL discard any read in flight when rst is asserted mid-operation (ram_rdata ignored the following cycle); RAM contents are not cleared.

Structure
REQ-032 SHALL take no shared-package typedefs beyond the common fifo package's address-width helper; WIDTH/DEPTH stay module parameters.
REQ-033 SHALL implement the 2-entry output buffer as sub-module fifo_obuf2 (push, pop, din, dout, valid, cnt).

Verification
REQ-034 Single push 0xA5A5 at cycle 0, out_ready=1 -> ram_wen cycle 0, ram_ren cycle 1, out_valid with 0xA5A5 at cycle 3, count returns to 0.
REQ-035 Push 34 words 0..33, out_ready=0 -> DEPTH+2 = 34 accepted, in_ready low after, count=34, then drain yields 0..33 in order.
REQ-036 Continuous in_valid and out_ready, 100 words -> ram_wen and ram_ren never coincide, order preserved, rptr/wptr wrap past 31 correctly.
REQ-037 out_ready toggled randomly with obuf full -> out_data stable while stalled, no loss or duplication.
REQ-038 rst asserted in cycle with rd_pend=1 -> next cycle count=0, out_valid=0; subsequent push 0x1234 emerges alone.

Source files
------------

// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared helpers for the single-port-RAM FIFO controller.
// Only the address-width helper lives here; data width and depth stay module parameters.
package spram_fifo_ctrl_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spram_fifo_ctrl_obuf2.sv
// Two-entry output skid buffer: slot 0 is always the head, slot 1 the tail.
// A simultaneous push and pop are both honoured and keep arrival order.
module fifo_obuf2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       cnt
);

    logic [1:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0] slot0_reg, slot0_next;
    logic [WIDTH-1:0] slot1_reg, slot1_next;

    always_comb begin
        slot0_next = slot0_reg;
        slot1_next = slot1_reg;
        cnt_next   = cnt_reg;
        if (pop && (cnt_reg != 2'd0)) begin
            slot0_next = slot1_reg;
            cnt_next   = cnt_reg - 2'd1;
        end
        // The tail slot is chosen from the occupancy left after any pop.
        if (push && (cnt_next != 2'd2)) begin
            if (cnt_next == 2'd0) begin
                slot0_next = din;
            end else begin
                slot1_next = din;
            end
            cnt_next = cnt_next + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= 2'd0;
            slot0_reg <= '0;
            slot1_reg <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            slot0_reg <= slot0_next;
            slot1_reg <= slot1_next;
        end
    end

    assign dout  = slot0_reg;
    assign valid = (cnt_reg != 2'd0);
    assign cnt   = cnt_reg;

endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller for an external single-port RAM with a registered read port.
// Reads take priority over writes; a 2-entry buffer hides the RAM read latency.
module spram_fifo_ctrl
    import spram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+3)-1:0] count,
    output logic                       ram_wen,
    output logic                       ram_ren,
    output logic [addr_w(DEPTH)-1:0]   ram_waddr,
    output logic [addr_w(DEPTH)-1:0]   ram_raddr,
    output logic [WIDTH-1:0]           ram_wdata,
    input  logic [WIDTH-1:0]           ram_rdata
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 3);
    localparam logic [AW:0] RAM_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wptr_reg;
    logic [AW-1:0]    rptr_reg;
    logic [AW:0]      ram_cnt_reg;
    logic             rd_pend_reg;

    logic [1:0]       obuf_cnt;
    logic [1:0]       obuf_occ;
    logic [WIDTH-1:0] obuf_dout;
    logic             obuf_valid;
    logic             rd_issue;
    logic             push;
    logic             pop;

    // Buffer slots already claimed, including a read whose data arrives next cycle.
    assign obuf_occ = obuf_cnt + {1'b0, rd_pend_reg};
    assign rd_issue = !rst && (ram_cnt_reg != '0) && (obuf_occ < 2'd2);
    assign in_ready = !rst && (ram_cnt_reg != RAM_FULL) && !rd_issue;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            ram_cnt_reg <= '0;
            rd_pend_reg <= 1'b0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (rd_issue) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            ram_cnt_reg <= ram_cnt_reg + (AW + 1)'(push) - (AW + 1)'(rd_issue);
            rd_pend_reg <= rd_issue;
        end
    end

    // Reset wins over a capture, so a read in flight at reset is dropped.
    fifo_obuf2 #(
        .WIDTH(WIDTH)
    ) u_obuf (
        .clk  (clk),
        .rst  (rst),
        .push (rd_pend_reg && !rst),
        .pop  (pop),
        .din  (ram_rdata),
        .dout (obuf_dout),
        .valid(obuf_valid),
        .cnt  (obuf_cnt)
    );

    assign out_valid = !rst && obuf_valid;
    assign out_data  = rst ? '0 : obuf_dout;
    assign count     = rst ? '0 : (CW'(ram_cnt_reg) + CW'(rd_pend_reg) + CW'(obuf_cnt));
    assign ram_wen   = push;
    assign ram_ren   = rd_issue;
    assign ram_waddr = rst ? '0 : wptr_reg;
    assign ram_raddr = rst ? '0 : rptr_reg;
    assign ram_wdata = rst ? '0 : in_data;

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Self-checking bench for spram_fifo_ctrl: behavioural RAM, queue reference model,
// one task per scenario with inline comparisons.
module tb_spram_fifo_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             ram_wen;
    logic             ram_ren;
    logic [AW-1:0]    ram_waddr;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    always #5 clk = ~clk;

    spram_fifo_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .ram_wen  (ram_wen),
        .ram_ren  (ram_ren),
        .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Single-port RAM with one-cycle registered read.
    logic [WIDTH-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram_mem[ram_raddr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] model_q [$];

    logic             obs_push, obs_pop, obs_valid, obs_wen, obs_ren, obs_in_ready, obs_ordy;
    logic [WIDTH-1:0] obs_data;
    logic [CW-1:0]    obs_count;
    int               obs_model_cnt;

    // Sample at the falling edge, record accepted pushes into the model, then advance.
    task automatic tick();
        @(negedge clk);
        obs_in_ready  = in_ready;
        obs_push      = in_valid && in_ready;
        obs_valid     = out_valid;
        obs_ordy      = out_ready;
        obs_pop       = out_valid && out_ready;
        obs_data      = out_data;
        obs_wen       = ram_wen;
        obs_ren       = ram_ren;
        obs_count     = count;
        obs_model_cnt = model_q.size();
        if (obs_push && !rst) model_q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] model_pop();
        if (model_q.size() == 0) return 'x;
        return model_q.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h5555; out_ready = 1'b1;
        repeat (3) begin
            tick();
            n_tests++;
            if (obs_in_ready !== 1'b0 || obs_valid !== 1'b0 || obs_wen !== 1'b0 || obs_ren !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs got in_ready=%b out_valid=%b wen=%b ren=%b required all 0",
                         obs_in_ready, obs_valid, obs_wen, obs_ren);
            end
            n_tests++;
            if (obs_count !== '0) begin
                n_fail++;
                $display("FAIL reset_count got %0d required 0", obs_count);
            end
        end
        rst = 1'b0; in_valid = 1'b0; model_q.delete();
        tick();
        n_tests++;
        if (obs_count !== '0 || obs_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle got count=%0d out_valid=%b in_ready=%b required 0/0/1",
                     obs_count, obs_valid, obs_in_ready);
        end
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] exp;
        in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
        tick();
        n_tests++;
        if (obs_wen !== 1'b1 || obs_ren !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c0 got wen=%b ren=%b required 1/0", obs_wen, obs_ren);
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (obs_ren !== 1'b1 || obs_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1 got wen=%b ren=%b required 0/1", obs_wen, obs_ren);
        end
        tick();
        n_tests++;
        if (obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c2 got out_valid=%b required 0", obs_valid);
        end
        tick();
        n_tests++;
        exp = model_pop();
        if (obs_valid !== 1'b1 || obs_data !== exp) begin
            n_fail++;
            $display("FAIL single_c3 got out_valid=%b data=%h required 1/%h", obs_valid, obs_data, exp);
        end
        tick();
        n_tests++;
        if (obs_count !== '0 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c4 got count=%0d out_valid=%b required 0/0", obs_count, obs_valid);
        end
    endtask

    task automatic test_fill();
        int sent = 0;
        int cyc = 0;
        logic [WIDTH-1:0] exp;
        out_ready = 1'b0;
        while (sent < DEPTH + 2 && cyc < 300) begin
            in_valid = 1'b1; in_data = WIDTH'(sent);
            tick();
            if (obs_push) sent++;
            cyc++;
        end
        n_tests++;
        if (sent != DEPTH + 2) begin
            n_fail++;
            $display("FAIL fill_accept got %0d pushes required %0d", sent, DEPTH + 2);
        end
        repeat (8) begin
            in_valid = 1'b1; in_data = 16'hDEAD;
            tick();
            n_tests++;
            if (obs_push !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_full_in_ready got in_ready=%b required 0", obs_in_ready);
            end
        end
        n_tests++;
        if (obs_count !== CW'(DEPTH + 2)) begin
            n_fail++;
            $display("FAIL fill_count got %0d required %0d", obs_count, DEPTH + 2);
        end
        in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
        while (model_q.size() > 0 && cyc < 300) begin
            tick();
            if (obs_pop) begin
                n_tests++;
                exp = model_pop();
                if (obs_data !== exp) begin
                    n_fail++;
                    $display("FAIL fill_drain_data got %h required %h", obs_data, exp);
                end
            end
            cyc++;
        end
        tick();
        n_tests++;
        if (model_q.size() != 0 || obs_count !== '0 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_drain_end got count=%0d left=%0d required 0/0", obs_count, model_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int cyc = 0;
        logic [WIDTH-1:0] exp;
        out_ready = 1'b1;
        while ((sent < 100 || model_q.size() > 0) && cyc < 2000) begin
            in_valid = (sent < 100);
            in_data  = WIDTH'($urandom);
            tick();
            if (obs_push) sent++;
            n_tests++;
            if (obs_wen && obs_ren) begin
                n_fail++;
                $display("FAIL b2b_port_conflict got wen=1 ren=1 required not both");
            end
            if (obs_pop) begin
                n_tests++;
                exp = model_pop();
                if (obs_data !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_data got %h required %h", obs_data, exp);
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (sent != 100 || model_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_complete got sent=%0d left=%0d required 100/0", sent, model_q.size());
        end
    endtask

    task automatic test_stall();
        logic             prev_stall = 1'b0;
        logic [WIDTH-1:0] prev_data = '0;
        logic [WIDTH-1:0] exp;
        int               cyc = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom % 4) == 0;
            tick();
            if (prev_stall) begin
                n_tests++;
                if (obs_valid !== 1'b1 || obs_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold got valid=%b data=%h required 1/%h", obs_valid, obs_data, prev_data);
                end
            end
            n_tests++;
            if (obs_count !== CW'(obs_model_cnt)) begin
                n_fail++;
                $display("FAIL stall_count got %0d required %0d", obs_count, obs_model_cnt);
            end
            if (obs_pop) begin
                n_tests++;
                exp = model_pop();
                if (obs_data !== exp) begin
                    n_fail++;
                    $display("FAIL stall_data got %h required %h", obs_data, exp);
                end
            end
            prev_stall = obs_valid && !obs_ordy;
            prev_data  = obs_data;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        while (model_q.size() > 0 && cyc < 300) begin
            tick();
            if (obs_pop) begin
                n_tests++;
                exp = model_pop();
                if (obs_data !== exp) begin
                    n_fail++;
                    $display("FAIL stall_drain_data got %h required %h", obs_data, exp);
                end
            end
            cyc++;
        end
        tick();
        n_tests++;
        if (model_q.size() != 0 || obs_count !== '0) begin
            n_fail++;
            $display("FAIL stall_drain_end got count=%0d left=%0d required 0/0", obs_count, model_q.size());
        end
    endtask

    task automatic test_reset_in_flight();
        int n_pops = 0;
        logic [WIDTH-1:0] exp;
        in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (obs_count !== '0 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstfl_during got count=%0d out_valid=%b required 0/0", obs_count, obs_valid);
        end
        rst = 1'b0; model_q.delete();
        tick();
        n_tests++;
        if (obs_count !== '0 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstfl_after got count=%0d out_valid=%b required 0/0", obs_count, obs_valid);
        end
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) begin
            tick();
            if (obs_pop) begin
                n_pops++;
                n_tests++;
                exp = model_pop();
                if (obs_data !== exp) begin
                    n_fail++;
                    $display("FAIL rstfl_data got %h required %h", obs_data, exp);
                end
            end
        end
        n_tests++;
        if (n_pops != 1) begin
            n_fail++;
            $display("FAIL rstfl_pop_count got %0d pops required 1", n_pops);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_stall();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
